// File: rtl/serial_byte_receiver.sv
// Serial-in, parallel-out receiver for LSB-first frames with a valid/ready output and sticky overrun.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit per frame and report parity_err.
module serial_byte_receiver #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sin_start,
   input  logic              sin_valid,
   input  logic              sin,
   output logic              rx_busy,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              overrun,
   input  logic              ovr_clr,
   output logic              parity_err
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef PARITY_CHECK_EN
   typedef enum logic [1:0] {IDLE, RECV, PARITY} state_t;
`else
   typedef enum logic [0:0] {IDLE, RECV} state_t;
`endif

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   sreg_q, sreg_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic                overrun_q, overrun_d;
   logic                rx_busy_q, rx_busy_d;
   logic                commit;
   logic [DATA_W-1:0]   commit_word;
   logic                commit_par;

   // The final strobe of a frame always commits, even when sin_start arrives on the same edge.
`ifdef PARITY_CHECK_EN
   logic parity_err_q, parity_err_d;

   assign commit      = (state_q == PARITY) && sin_valid;
   assign commit_word = sreg_q;
   assign commit_par  = (^sreg_q) ^ sin;
`else
   logic unused_sreg_lsb;

   assign unused_sreg_lsb = sreg_q[0];
   assign commit      = (state_q == RECV) && sin_valid && (cnt_q == LAST_BIT);
   assign commit_word = {sin, sreg_q[DATA_W-1:1]};
   assign commit_par  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sreg_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
         rx_busy_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sreg_q       <= sreg_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
         rx_busy_q    <= rx_busy_d;
`ifdef PARITY_CHECK_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      if (sin_start) begin
         state_d = RECV;
      end else begin
         case (state_q)
            RECV: begin
               if (sin_valid && (cnt_q == LAST_BIT)) begin
`ifdef PARITY_CHECK_EN
                  state_d = PARITY;
`else
                  state_d = IDLE;
`endif
               end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
               if (sin_valid) state_d = IDLE;
            end
`endif
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      cnt_d        = cnt_q;
      sreg_d       = sreg_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = overrun_q;
`ifdef PARITY_CHECK_EN
      parity_err_d = parity_err_q;
`endif
      if (sin_start) begin
         cnt_d  = '0;
         sreg_d = '0;
      end else if ((state_q == RECV) && sin_valid) begin
         sreg_d = {sin, sreg_q[DATA_W-1:1]};
         cnt_d  = cnt_q + CNT_W'(1);
      end

      // A drop on the same edge as ovr_clr must leave the flag set.
      if (ovr_clr) overrun_d = 1'b0;
      if (commit) begin
         if (!dout_valid_q || dout_ready) begin
            dout_d       = commit_word;
            dout_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
            parity_err_d = commit_par;
`endif
         end else begin
            overrun_d = 1'b1;
         end
      end else if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end

      rx_busy_d = (state_d != IDLE);
   end

   assign rx_busy    = rx_busy_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign overrun    = overrun_q;
`ifdef PARITY_CHECK_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Scoreboard bench for serial_byte_receiver: a bit-list reference model queues expected words,
// and a negedge monitor pops and compares them whenever the DUT hands a word over.
module tb_serial_byte_receiver;

   localparam int W = 8;
`ifdef PARITY_CHECK_EN
   localparam int FRAME_LEN = W + 1;
   localparam bit PAR_EN = 1'b1;
`else
   localparam int FRAME_LEN = W;
   localparam bit PAR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         sin_start = 1'b0;
   logic         sin_valid = 1'b0;
   logic         sin = 1'b0;
   logic         rx_busy;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready = 1'b0;
   logic         overrun;
   logic         ovr_clr = 1'b0;
   logic         parity_err;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0] word;
      logic         par;
   } exp_t;

   exp_t expQ[$];
   bit   mBits[$];
   bit   mBusy = 1'b0;
   bit   mValid = 1'b0;
   bit   mOverrun = 1'b0;
   bit   mDoutZero = 1'b1;
   bit   monOn = 1'b0;

   always #5 clk = ~clk;

   serial_byte_receiver #(.DATA_W(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .sin_start  (sin_start),
      .sin_valid  (sin_valid),
      .sin        (sin),
      .rx_busy    (rx_busy),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overrun    (overrun),
      .ovr_clr    (ovr_clr),
      .parity_err (parity_err)
   );

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   // Reference model: collects frame bits in a list and assembles the word arithmetically.
   task automatic modelStep();
      bit           consume;
      bit           commit;
      int           ones;
      exp_t         e;
      if (!reset_n) begin
         mBusy = 0; mValid = 0; mOverrun = 0; mDoutZero = 1;
         mBits.delete();
         expQ.delete();
         return;
      end
      consume = mValid && dout_ready;
      commit  = 0;
      e.word  = '0;
      e.par   = 1'b0;
      if (mBusy && sin_valid && (mBits.size() == FRAME_LEN - 1)) begin
         commit = 1;
         ones   = 0;
         for (int i = 0; i < FRAME_LEN - 1; i++) ones += mBits[i];
         ones += sin;
         for (int i = 0; i < W; i++) e.word[i] = (i < FRAME_LEN - 1) ? mBits[i] : sin;
         if (PAR_EN) e.par = (ones % 2) != 0;
      end
      if (sin_start) begin
         mBusy = 1;
         mBits.delete();
      end else if (commit) begin
         mBusy = 0;
      end else if (mBusy && sin_valid) begin
         mBits.push_back(sin);
      end
      if (ovr_clr) mOverrun = 0;
      if (commit) begin
         if (!mValid || consume) begin
            expQ.push_back(e);
            mValid = 1;
            mDoutZero = 0;
         end else begin
            mOverrun = 1;
         end
      end else if (consume) begin
         mValid = 0;
      end
   endtask

   task automatic applyStimulus(input bit rn, input bit s, input bit v, input bit b,
                                input bit r, input bit c);
      reset_n    = rn;
      sin_start  = s;
      sin_valid  = v;
      sin        = b;
      dout_ready = r;
      ovr_clr    = c;
      @(posedge clk);
      modelStep();
      monOn = 1;
      #1;
   endtask

   task automatic checkOutput();
      exp_t e;
      cmp("rx_busy", 32'(rx_busy), 32'(mBusy));
      cmp("dout_valid", 32'(dout_valid), 32'(mValid));
      cmp("overrun", 32'(overrun), 32'(mOverrun));
      if (mDoutZero) begin
         cmp("dout_after_reset", 32'(dout), 32'h0);
         cmp("parity_err_after_reset", 32'(parity_err), 32'h0);
      end
      if (dout_valid === 1'b1 && dout_ready === 1'b1 && reset_n === 1'b1) begin
         if (expQ.size() == 0) begin
            cmp("unexpected_word", 32'(dout), 32'hFFFF_FFFF);
         end else begin
            e = expQ.pop_front();
            cmp("dout_word", 32'(dout), 32'(e.word));
            cmp("parity_err", 32'(parity_err), 32'(e.par));
         end
      end
   endtask

   always @(negedge clk) begin
      if (monOn) checkOutput();
   end

   task automatic sendFrame(input logic [W-1:0] w, input bit parBit, input bit rdy);
      applyStimulus(1, 1, 0, 0, rdy, 0);
      for (int i = 0; i < W; i++) applyStimulus(1, 0, 1, w[i], rdy, 0);
      if (PAR_EN) applyStimulus(1, 0, 1, parBit, rdy, 0);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, rdy, 0);
   endtask

   initial begin
      // Reset with random inputs, then strobes with no start.
      for (int i = 0; i < 2; i++)
         applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 1'($urandom), 1, 0);

      // Basic frame 0x4D.
      sendFrame(8'h4D, 1'b0, 1'b1);
      idle(3, 1'b1);

      // Overrun: second word dropped, clear flag, then consume.
      sendFrame(8'hA5, 1'b0, 1'b0);
      sendFrame(8'h3C, 1'b0, 1'b0);
      idle(2, 1'b0);
      applyStimulus(1, 0, 0, 0, 0, 1);
      idle(2, 1'b0);
      idle(3, 1'b1);

      // Abort with start coinciding with a strobe, then eight ones.
      applyStimulus(1, 1, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 1'(i % 2), 1, 0);
      applyStimulus(1, 1, 1, 1, 1, 0);
      for (int i = 0; i < W; i++) applyStimulus(1, 0, 1, 1, 1, 0);
      if (PAR_EN) applyStimulus(1, 0, 1, 0, 1, 0);
      idle(3, 1'b1);

      // Parity good and bad.
      sendFrame(8'h4D, 1'b0, 1'b1);
      sendFrame(8'h4D, 1'b1, 1'b1);
      idle(3, 1'b1);

      // Reset mid-frame, ignored strobes, then 0x81.
      applyStimulus(1, 1, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 1, 1, 0);
      sendFrame(8'h81, 1'b0, 1'b1);
      idle(3, 1'b1);

      // Randomized traffic with sparse and back-to-back strobes.
      for (int i = 0; i < 3000; i++)
         applyStimulus(($urandom_range(0, 399) != 0),
                       ($urandom_range(0, 29) == 0),
                       ($urandom_range(0, 1) == 0),
                       1'($urandom),
                       ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 19) == 0));

      idle(5, 1'b1);
      cmp("scoreboard_empty", 32'(expQ.size()), 32'h0);
      monOn = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_byte_receiver.md
# serial_byte_receiver

Serial-in, parallel-out receiver that reassembles bytes shifted out LSB-first by the lab-board right-shift register. It sits at the far end of a one-bit serial link and presents each completed word on a registered parallel output with a valid/ready handshake. A sticky overrun flag records any word lost because the consumer had not accepted the previous one. An optional even-parity check can be compiled in.

## Interface
- DATA_W, 8, number of data bits per frame (>= 2).
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- sin_start  in  1  frame-start pulse; arms the receiver and aborts any frame in progress.
- sin_valid  in  1  bit strobe; `sin` is sampled on an edge where this is high.
- sin  in  1  serial data bit, LSB first.
- rx_busy  out  1  high while a frame is being received (state != IDLE).
- dout  out  DATA_W  last committed word.
- dout_valid  out  1  `dout` holds an unconsumed word.
- dout_ready  in  1  consumer accepts `dout` on an edge where `dout_valid && dout_ready`.
- overrun  out  1  sticky; a completed word was dropped.
- ovr_clr  in  1  clears `overrun`.
- parity_err  out  1  parity result for the word in `dout`; meaningful only while `dout_valid` is high.

## Operation
- States: IDLE, RECV, PARITY. PARITY exists only when the macro is defined.
- Reset: state IDLE; bit counter 0; shift register 0; `dout` 0; `dout_valid` 0; `overrun` 0; `parity_err` 0; `rx_busy` 0.
- IDLE:
  - `sin_valid` is ignored.
  - On `sin_start`, go to RECV; clear the counter and the shift register.
- RECV:
  - On `sin_valid`: shift register <= {sin, sreg[DATA_W-1:1]} (right shift, new bit enters at MSB); counter increments.
  - On the strobe with counter == DATA_W-1, the frame data is complete. Without the macro, commit and go to IDLE. With the macro, go to PARITY.
- PARITY: on `sin_valid`, commit with parity_err_new = XOR(sreg) ^ sin (even parity; 1 means error), then go to IDLE.
- `sin_start` in RECV or PARITY: discard the partial frame, clear the counter and shift register, stay in or return to RECV. When `sin_start` and `sin_valid` coincide, start wins and the bit is discarded.
- Commit:
  - If `dout_valid` is low, or `dout_valid && dout_ready` on the same edge: load `dout` and `parity_err`, and set `dout_valid` to 1.
  - Otherwise (previous word unconsumed): drop the new word; `dout` and `parity_err` are unchanged; set `overrun`.
- Consume: `dout_valid && dout_ready` with no commit on that edge clears `dout_valid`. `dout` keeps its value.
- `ovr_clr` clears `overrun`. When a set and `ovr_clr` occur on the same edge, the set wins.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Latency: `dout` and `dout_valid` update on the same edge that samples the final strobe (last data bit, or the parity bit). They are visible in the following cycle.
- Strobes may be back-to-back (one bit per cycle) or sparse; there is no timeout.
- `rx_busy` rises the cycle after `sin_start` and falls the cycle after the commit edge.
- Reset has priority over every input, including mid-frame and mid-handshake. The partial frame and any pending word are lost.
- A new frame can start on the edge immediately after commit. A `sin_start` on the commit edge itself is honoured and does not block the commit.

## Configuration
- PARITY_CHECK_EN defined:
  - A frame is DATA_W data bits followed by one even-parity bit.
  - PARITY state is present.
  - `parity_err` is computed as above.
- PARITY_CHECK_EN undefined:
  - A frame is DATA_W bits and commit occurs on the last data bit.
  - PARITY state is absent.
  - `parity_err` is tied to 0.

## Test plan
- Reset: assert reset_n=0 for 2 cycles with random inputs -> all outputs 0 and rx_busy=0. Strobes with no `sin_start` leave dout_valid=0.
- Basic frame: sin_start, then bits 1,0,1,1,0,0,1,0 on consecutive strobes, dout_ready=1 -> dout=0x4D and dout_valid=1 for exactly one cycle; rx_busy falls the cycle after the final strobe.
- Overrun: dout_ready=0, receive 0xA5 then 0x3C -> dout stays 0xA5 and overrun=1. Pulse ovr_clr -> overrun=0. Raise dout_ready -> dout_valid clears.
- Abort and simultaneous events: sin_start, 5 bits, then sin_start coinciding with sin_valid, then 8 ones -> exactly one commit, dout=0xFF.
- Parity (macro defined): 0x4D followed by parity bit 0 -> parity_err=0. 0x4D followed by parity bit 1 -> parity_err=1. Macro undefined: 0x4D commits after 8 strobes with parity_err=0.
- Reset mid-frame: after 4 bits, reset_n=0 for 1 cycle -> state IDLE. Subsequent strobes are ignored until sin_start; the next full frame 0x81 gives dout=0x81.
